// File: rtl/demux_l2_sched.sv
`default_nettype none
// ============================================================================
//  Module   : demux_l2_sched
//  Purpose  : Flow controller and lane scheduler for the L2 1:2 demux stage
//             (clk_4f domain). Buffers the incoming word stream in a small
//             circular FIFO and issues word k to lane (k mod 2) in strict
//             alternation, stalling on per-lane almost-full backpressure.
//             Upstream is throttled through ready_out; issue order is never
//             reordered or skipped.
//  Ports    :
//    clk_4f     in   1       sole clock, rising edge
//    reset_L    in   1       synchronous, active-low reset
//    valid      in   1       upstream word valid
//    data_in    in   DATA_W  upstream word
//    ready_out  out  1       buffer can accept (valid && ready_out = push)
//    afull0     in   1       lane-0 downstream almost-full
//    afull1     in   1       lane-1 downstream almost-full
//    validout0  out  1       lane-0 word valid, one cycle per word
//    validout1  out  1       lane-1 word valid, one cycle per word
//    dataout0   out  DATA_W  lane-0 word (holds when not issuing)
//    dataout1   out  DATA_W  lane-1 word (holds when not issuing)
//    state      out  2       0=IDLE, 1=RUN, 2=STALL
//    err_stall  out  1       sticky stall-timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module demux_l2_sched #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 2,
    parameter int STALL_MAX = 15
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    input  logic              afull0,
    input  logic              afull1,
    output logic              validout0,
    output logic              validout1,
    output logic [DATA_W-1:0] dataout0,
    output logic [DATA_W-1:0] dataout1,
    output logic [1:0]        state,
    output logic              err_stall
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int SC_W  = $clog2(STALL_MAX + 1);

    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(BUF_DEPTH);
    localparam logic [SC_W-1:0]  c_stall_max = SC_W'(STALL_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_lane_ptr;

    state_t            r_state;
    state_t            w_state_next;

    logic [SC_W-1:0]   r_stall_cnt;
    logic [SC_W-1:0]   w_stall_cnt_next;
    logic              r_err;

    logic [1:0]        w_afull;
    logic              w_afull_sel;
    logic              w_nonempty;
    logic              w_push;
    logic              w_pop;
    logic              w_stall;
    logic [DATA_W-1:0] w_head;

    // ------------------------------------------------------------------------
    // Handshake and issue decision
    // ------------------------------------------------------------------------
    assign w_afull     = {afull1, afull0};
    // Only the lane the next word is destined for can block; the other
    // lane's almost-full is irrelevant this cycle.
    assign w_afull_sel = w_afull[r_lane_ptr];
    assign w_nonempty  = (r_count != '0);
    assign w_pop       = w_nonempty && !w_afull_sel;
    assign w_stall     = w_nonempty &&  w_afull_sel;

    // Based on the registered count only: a full buffer never accepts in the
    // cycle it pops, so ready_out reopens one cycle after the pop.
    assign ready_out   = reset_L && (r_count < c_depth);
    assign w_push      = valid && ready_out;
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Circular buffer. Storage is not reset; clearing the pointers and count
    // is enough to discard every buffered word.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_4f) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lane_ptr <= 1'b0;
        end else begin
            // BUF_DEPTH is a power of two, so the pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_lane_ptr <= ~r_lane_ptr;
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Per-lane output registers
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < 2; g++) begin : g_lane
            logic              r_valid;
            logic [DATA_W-1:0] r_data;
            logic              w_issue;

            assign w_issue = w_pop && (r_lane_ptr == 1'(g));

            always_ff @(posedge clk_4f) begin
                if (!reset_L) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= w_issue;
                    if (w_issue) begin
                        r_data <= w_head;
                    end
                end
            end
        end
    endgenerate

    assign validout0 = g_lane[0].r_valid;
    assign validout1 = g_lane[1].r_valid;
    assign dataout0  = g_lane[0].r_data;
    assign dataout1  = g_lane[1].r_data;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Decisions use the post-edge occupancy, so a word pushed into an empty
    // buffer moves IDLE to RUN on that same edge. While stalled no pop
    // happens, so w_stall implies a non-zero next count.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_count_next != '0) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN, ST_STALL: begin
                if (w_count_next == '0) begin
                    w_state_next = ST_IDLE;
                end else if (w_stall) begin
                    w_state_next = ST_STALL;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign state = r_state;

    // ------------------------------------------------------------------------
    // Stall watchdog: counts consecutive edges that leave the FSM in STALL,
    // saturating so the sticky flag cannot be missed by a wrap.
    // ------------------------------------------------------------------------
    always_comb begin
        w_stall_cnt_next = '0;
        if (w_state_next == ST_STALL) begin
            if (r_stall_cnt == c_stall_max) begin
                w_stall_cnt_next = r_stall_cnt;
            end else begin
                w_stall_cnt_next = r_stall_cnt + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_next;
            if (w_stall_cnt_next == c_stall_max) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_stall = r_err;

endmodule
`default_nettype wire
